// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
//   Nbits-wide ripple-carry adder split into Nstages register-separated slices of
//   W = Nbits/Nstages bits each. Stage k adds operand bits [k*W +: W] with the carry
//   registered by stage k-1 (stage 0 uses cin). Results leave the last stage after
//   exactly Nstages accepted cycles. One global enable (adv) advances the whole pipe,
//   so a stalled output freezes every register, including bubbles.
//
// Parameters
//   Nbits    operand/sum width, must be a multiple of Nstages
//   Nstages  number of slices, 1..Nbits
//   signd    0: overflow = carry out of MSB; 1: two's-complement overflow
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a/b/cin valid this cycle
//   in_ready   block accepts a/b/cin this cycle (combinational from out_valid/out_ready)
//   a, b       operands
//   cin        carry into bit 0
//   out_valid  sum/cout/overflow valid
//   out_ready  downstream accepts the result
//   sum        a + b + cin modulo 2^Nbits
//   cout       carry out of bit Nbits-1
//   overflow   cout when signd=0, signed overflow when signd=1
module pipelined_ripple_adder #(
  parameter int unsigned Nbits   = 8,
  parameter int unsigned Nstages = 4,
  parameter bit          signd   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Nbits-1:0] a,
  input  logic [Nbits-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned W    = Nbits / Nstages;
  localparam int unsigned Last = Nstages - 1;

  logic adv;

  // Per-stage registers. sum_q holds the slices produced so far at their final bit
  // positions; a_q/b_q carry the operands forward so later stages still see the
  // not-yet-added upper bits and the MSBs needed for signed overflow.
  logic [Nstages-1:0] valid_q;
  logic [Nstages-1:0] carry_q;
  logic [Nbits-1:0]   sum_q [Nstages];
  logic [Nbits-1:0]   a_q   [Nstages];
  logic [Nbits-1:0]   b_q   [Nstages];

  // Stage inputs: stage 0 takes the port values, stage k takes stage k-1's registers.
  logic [Nstages-1:0] valid_in;
  logic [Nstages-1:0] carry_in;
  logic [Nbits-1:0]   a_in   [Nstages];
  logic [Nbits-1:0]   b_in   [Nstages];
  logic [Nbits-1:0]   sum_in [Nstages];

  // Next-state for the slice adders.
  logic [Nbits-1:0]   sum_d [Nstages];
  logic [Nstages-1:0] carry_d;
  logic [W:0]         slice_tmp;

  // A stalled output holds the whole pipe, bubbles included.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < Nstages; k++) begin : g_link
    if (k == 0) begin : g_first
      assign valid_in[k] = in_valid;
      assign carry_in[k] = cin;
      assign a_in[k]     = a;
      assign b_in[k]     = b;
      assign sum_in[k]   = '0;
    end else begin : g_next
      assign valid_in[k] = valid_q[k-1];
      assign carry_in[k] = carry_q[k-1];
      assign a_in[k]     = a_q[k-1];
      assign b_in[k]     = b_q[k-1];
      assign sum_in[k]   = sum_q[k-1];
    end
  end

  // Each stage ripples only its own W-bit slice; lower slices pass through unchanged.
  always_comb begin
    slice_tmp = '0;
    carry_d   = '0;
    for (int k = 0; k < Nstages; k++) begin
      sum_d[k] = '0;
    end
    for (int k = 0; k < Nstages; k++) begin
      slice_tmp = {1'b0, a_in[k][k*W +: W]} + {1'b0, b_in[k][k*W +: W]}
                + {{W{1'b0}}, carry_in[k]};
      sum_d[k]             = sum_in[k];
      sum_d[k][k*W +: W]   = slice_tmp[W-1:0];
      carry_d[k]           = slice_tmp[W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < Nstages; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_in;
      carry_q <= carry_d;
      for (int k = 0; k < Nstages; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
      end
    end
  end

  assign out_valid = valid_q[Last];
  assign sum       = sum_q[Last];
  assign cout      = carry_q[Last];

  // Signed overflow: like-signed operands producing a result of the other sign.
  // Uses the operand MSBs carried down the pipe with the result.
  always_comb begin
    overflow = cout;
    if (signd) begin
      overflow = (a_q[Last][Nbits-1] == b_q[Last][Nbits-1]) &&
                 (sum_q[Last][Nbits-1] != a_q[Last][Nbits-1]);
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
module tb_pipelined_ripple_adder;

  localparam int NDUT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       cin = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       ir_v  [NDUT];
  logic       ov_v  [NDUT];
  logic       co_v  [NDUT];
  logic       of_v  [NDUT];
  logic [7:0] sum_v [NDUT];

  int stg [NDUT];
  bit sgn [NDUT];

  // Scoreboard per DUT: {overflow, cout, sum}
  logic [9:0] exp_q [NDUT][$];
  logic       pop   [NDUT];
  logic [9:0] obs   [NDUT];
  logic [9:0] expv  [NDUT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: 4 stages unsigned, 1: 4 stages signed, 2/3/4: 1/2/8 stages unsigned
  pipelined_ripple_adder #(.Nbits(8), .Nstages(4), .signd(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[0]), .a(a), .b(b), .cin(cin),
    .out_valid(ov_v[0]), .out_ready(out_ready), .sum(sum_v[0]), .cout(co_v[0]),
    .overflow(of_v[0]));
  pipelined_ripple_adder #(.Nbits(8), .Nstages(4), .signd(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[1]), .a(a), .b(b), .cin(cin),
    .out_valid(ov_v[1]), .out_ready(out_ready), .sum(sum_v[1]), .cout(co_v[1]),
    .overflow(of_v[1]));
  pipelined_ripple_adder #(.Nbits(8), .Nstages(1), .signd(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[2]), .a(a), .b(b), .cin(cin),
    .out_valid(ov_v[2]), .out_ready(out_ready), .sum(sum_v[2]), .cout(co_v[2]),
    .overflow(of_v[2]));
  pipelined_ripple_adder #(.Nbits(8), .Nstages(2), .signd(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[3]), .a(a), .b(b), .cin(cin),
    .out_valid(ov_v[3]), .out_ready(out_ready), .sum(sum_v[3]), .cout(co_v[3]),
    .overflow(of_v[3]));
  pipelined_ripple_adder #(.Nbits(8), .Nstages(8), .signd(1'b0)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_v[4]), .a(a), .b(b), .cin(cin),
    .out_valid(ov_v[4]), .out_ready(out_ready), .sum(sum_v[4]), .cout(co_v[4]),
    .overflow(of_v[4]));

  function automatic logic [9:0] model(input bit s, input logic [7:0] ai, input logic [7:0] bi,
                                       input logic ci);
    logic [8:0] t;
    logic       ovf;
    t   = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
    ovf = s ? ((ai[7] == bi[7]) && (t[7] != ai[7])) : t[8];
    return {ovf, t[8], t[7:0]};
  endfunction

  // Drives one cycle's inputs at the falling edge, then records what each DUT
  // hands over and accepts at the coming rising edge.
  task automatic cycle(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                       input logic ci, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    a         = ai;
    b         = bi;
    cin       = ci;
    out_ready = ordy;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      pop[d]  = 1'b0;
      obs[d]  = {of_v[d], co_v[d], sum_v[d]};
      expv[d] = 'x;
      if (ov_v[d] && ordy) begin
        pop[d] = 1'b1;
        if (exp_q[d].size() > 0) expv[d] = exp_q[d].pop_front();
      end
      if (v && ir_v[d]) exp_q[d].push_back(model(sgn[d], ai, bi, ci));
    end
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if ({ov_v[d], co_v[d], of_v[d], sum_v[d], ir_v[d]} !== {3'b000, 8'h00, 1'b1}) begin
        bad++;
        $display("FAIL reset_hold dut%0d got v=%b c=%b o=%b s=%h r=%b want 0 0 0 00 1", d,
                 ov_v[d], co_v[d], of_v[d], sum_v[d], ir_v[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if ({ov_v[d], sum_v[d], ir_v[d]} !== {1'b0, 8'h00, 1'b1}) begin
        bad++;
        $display("FAIL reset_release dut%0d got v=%b s=%h r=%b want 0 00 1", d, ov_v[d],
                 sum_v[d], ir_v[d]);
      end
    end
  endtask

  task automatic test_basic();
    int first [NDUT];
    for (int d = 0; d < NDUT; d++) first[d] = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) cycle(1'b1, 8'd200, 8'd100, 1'b0, 1'b1);
      else        cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      for (int d = 0; d < NDUT; d++) if (pop[d]) begin
        total++;
        if (obs[d] !== expv[d]) begin
          bad++;
          $display("FAIL basic_sb dut%0d got %h want %h", d, obs[d], expv[d]);
        end
      end
      for (int d = 0; d < NDUT; d++) if (ov_v[d] && first[d] < 0) first[d] = i;
      if (ov_v[0] && first[0] == i) begin
        total++;
        if ({of_v[0], co_v[0], sum_v[0]} !== {1'b1, 1'b1, 8'd44}) begin
          bad++;
          $display("FAIL basic_200p100 got o=%b c=%b s=%0d want 1 1 44", of_v[0], co_v[0],
                   sum_v[0]);
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (first[d] != stg[d] || exp_q[d].size() != 0) begin
        bad++;
        $display("FAIL basic_latency dut%0d got %0d left=%0d want %0d left=0", d, first[d],
                 exp_q[d].size(), stg[d]);
      end
    end
  endtask

  task automatic test_carry_chain();
    bit seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) cycle(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
      else        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int d = 0; d < NDUT; d++) if (pop[d]) begin
        total++;
        if (obs[d] !== expv[d]) begin
          bad++;
          $display("FAIL carry_sb dut%0d got %h want %h", d, obs[d], expv[d]);
        end
      end
      if (pop[0]) begin
        seen = 1'b1;
        total++;
        if ({co_v[0], sum_v[0]} !== {1'b1, 8'h00}) begin
          bad++;
          $display("FAIL carry_ff_plus_1 got c=%b s=%h want 1 00", co_v[0], sum_v[0]);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL carry_seen got 0 results want 1");
    end
  endtask

  task automatic test_signed();
    logic [7:0] va   [3];
    logic [7:0] vb   [3];
    logic [9:0] want [3];
    int         n = 0;
    va[0] = 8'd100; vb[0] = 8'd50;  want[0] = {1'b1, 1'b0, 8'h96};
    va[1] = 8'h80;  vb[1] = 8'hFF;  want[1] = {1'b1, 1'b1, 8'h7F};
    va[2] = 8'd127; vb[2] = 8'hFF;  want[2] = {1'b0, 1'b1, 8'd126};
    for (int i = 0; i < 16; i++) begin
      if (i < 3) cycle(1'b1, va[i], vb[i], 1'b0, 1'b1);
      else       cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int d = 0; d < NDUT; d++) if (pop[d]) begin
        total++;
        if (obs[d] !== expv[d]) begin
          bad++;
          $display("FAIL signed_sb dut%0d got %h want %h", d, obs[d], expv[d]);
        end
      end
      if (pop[1] && n < 3) begin
        total++;
        if (obs[1] !== want[n]) begin
          bad++;
          $display("FAIL signed_vec%0d got %h want %h", n, obs[1], want[n]);
        end
        n++;
      end
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL signed_count got %0d want 3", n);
    end
  endtask

  task automatic test_back_to_back();
    int first [NDUT];
    int last  [NDUT];
    int cnt   [NDUT];
    for (int d = 0; d < NDUT; d++) begin
      first[d] = -1; last[d] = -1; cnt[d] = 0;
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 16) cycle(1'b1, 8'(i), 8'(i), 1'b1, 1'b1);
      else        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int d = 0; d < NDUT; d++) if (pop[d]) begin
        total++;
        if (obs[d] !== expv[d]) begin
          bad++;
          $display("FAIL stream_sb dut%0d got %h want %h", d, obs[d], expv[d]);
        end
        if (first[d] < 0) first[d] = i;
        last[d] = i;
        cnt[d]++;
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (cnt[d] != 16 || first[d] != stg[d] || last[d] != stg[d] + 15) begin
        bad++;
        $display("FAIL stream_shape dut%0d got cnt=%0d first=%0d last=%0d want 16 %0d %0d",
                 d, cnt[d], first[d], last[d], stg[d], stg[d] + 15);
      end
    end
  endtask

  task automatic test_stall();
    logic ordy;
    for (int i = 0; i < 30; i++) begin
      ordy = !(i >= 4 && i < 7);
      cycle(i < 11, 8'(i * 17), 8'(i * 3 + 1), i[0], ordy);
      if (!ordy) begin
        for (int d = 0; d < NDUT; d++) if (stg[d] <= 4) begin
          total++;
          if (ir_v[d] !== 1'b0 || ov_v[d] !== 1'b1 || exp_q[d].size() == 0 ||
              obs[d] !== exp_q[d][0]) begin
            bad++;
            $display("FAIL stall_hold dut%0d got r=%b v=%b out=%h want r=0 v=1 out=head", d,
                     ir_v[d], ov_v[d], obs[d]);
          end
        end
      end
      for (int d = 0; d < NDUT; d++) if (pop[d]) begin
        total++;
        if (obs[d] !== expv[d]) begin
          bad++;
          $display("FAIL stall_sb dut%0d got %h want %h", d, obs[d], expv[d]);
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (exp_q[d].size() != 0) begin
        bad++;
        $display("FAIL stall_drain dut%0d got left=%0d want 0", d, exp_q[d].size());
      end
    end
  endtask

  task automatic test_mid_reset();
    int stray = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 5), 8'(i + 9), 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if ({ov_v[d], co_v[d], sum_v[d]} !== {2'b00, 8'h00}) begin
        bad++;
        $display("FAIL midrst_flush dut%0d got v=%b c=%b s=%h want 0 0 00", d, ov_v[d],
                 co_v[d], sum_v[d]);
      end
      exp_q[d].delete();
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int d = 0; d < NDUT; d++) if (ov_v[d]) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL midrst_stray got %0d results want 0", stray);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 340; i++) begin
      if (i < 300)
        cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0);
      else
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int d = 0; d < NDUT; d++) if (pop[d]) begin
        total++;
        if (obs[d] !== expv[d]) begin
          bad++;
          $display("FAIL random_sb dut%0d got %h want %h", d, obs[d], expv[d]);
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (exp_q[d].size() != 0) begin
        bad++;
        $display("FAIL random_drain dut%0d got left=%0d want 0", d, exp_q[d].size());
      end
    end
  endtask

  initial begin
    stg[0] = 4; sgn[0] = 1'b0;
    stg[1] = 4; sgn[1] = 1'b1;
    stg[2] = 1; sgn[2] = 1'b0;
    stg[3] = 2; sgn[3] = 1'b0;
    stg[4] = 8; sgn[4] = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_signed();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
